// File: rtl/btb_update_queue.sv
// btb_update_queue
// Buffers resolved taken-branch updates from the execute stage. Each entry is
// split into BTB index and tag. Entries drain one per cycle into the single
// BTB write port, in FIFO order.
//
// Optional feature: define BTBQ_COALESCE_EN to merge an accepted push into
// the youngest occupied entry that has the same index.
//
// Ports:
//   clk_i, rst_i       clock; asynchronous active-high reset
//   ex_valid_i         execute stage presents a resolved branch
//   ex_taken_i         branch resolved taken (only taken branches are queued)
//   ex_pc_i            branch PC
//   ex_target_i        resolved target
//   ready_o            queue not full (registered state only)
//   drain_stall_i      suppress draining this cycle
//   wren_o             BTB write enable (pop this cycle)
//   wr_index_o         head entry index
//   wr_tag_o           head entry tag
//   wr_target_o        head entry target
//   count_o            occupied entries
module btb_update_queue #(
  parameter int unsigned INDEX_WIDTH = 12,
  parameter int unsigned DEPTH       = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        ex_valid_i,
  input  logic                        ex_taken_i,
  input  logic [31:0]                 ex_pc_i,
  input  logic [31:0]                 ex_target_i,
  output logic                        ready_o,
  input  logic                        drain_stall_i,
  output logic                        wren_o,
  output logic [INDEX_WIDTH-1:0]      wr_index_o,
  output logic [32-INDEX_WIDTH-3:0]   wr_tag_o,
  output logic [31:0]                 wr_target_o,
  output logic [$clog2(DEPTH):0]      count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned TAG_W = 32 - INDEX_WIDTH - 2;

  logic [INDEX_WIDTH-1:0] idx_q [DEPTH];
  logic [TAG_W-1:0]       tag_q [DEPTH];
  logic [31:0]            tgt_q [DEPTH];

  logic [PTR_W-1:0] head_q;
  logic [PTR_W-1:0] tail_q;
  logic [CNT_W-1:0] count_q;

  logic                   push;
  logic                   pop;
  logic                   alloc;
  logic [INDEX_WIDTH-1:0] new_idx;
  logic [TAG_W-1:0]       new_tag;

  // Byte-offset bits of the PC carry no BTB information.
  logic unused_pc_lsbs;
  assign unused_pc_lsbs = ^ex_pc_i[1:0];

  assign new_idx = ex_pc_i[INDEX_WIDTH+1:2];
  assign new_tag = ex_pc_i[31:INDEX_WIDTH+2];

  assign ready_o = (count_q < CNT_W'(DEPTH));
  assign push    = ex_valid_i & ex_taken_i & ready_o;
  assign pop     = (count_q != '0) & ~drain_stall_i;

`ifdef BTBQ_COALESCE_EN
  logic             hit;
  logic [PTR_W-1:0] hit_slot;
  logic [PTR_W-1:0] slot;

  // Walk from oldest to youngest so the last match (youngest) wins.
  // The head being popped this cycle is excluded: it is already leaving.
  always_comb begin
    hit      = 1'b0;
    hit_slot = '0;
    slot     = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      slot = head_q + PTR_W'(k);
      if ((CNT_W'(k) < count_q) && (idx_q[slot] == new_idx) && !((k == 0) && pop)) begin
        hit      = 1'b1;
        hit_slot = slot;
      end
    end
  end

  assign alloc = push & ~hit;
`else
  assign alloc = push;
`endif

  // Pointer, occupancy and entry storage.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        idx_q[i] <= '0;
        tag_q[i] <= '0;
        tgt_q[i] <= '0;
      end
    end else begin
      if (alloc) begin
        idx_q[tail_q] <= new_idx;
        tag_q[tail_q] <= new_tag;
        tgt_q[tail_q] <= ex_target_i;
        tail_q        <= tail_q + PTR_W'(1);
      end
`ifdef BTBQ_COALESCE_EN
      if (push && hit) begin
        tag_q[hit_slot] <= new_tag;
        tgt_q[hit_slot] <= ex_target_i;
      end
`endif
      if (pop) begin
        head_q <= head_q + PTR_W'(1);
      end
      count_q <= count_q + CNT_W'(alloc) - CNT_W'(pop);
    end
  end

  // Head entry is always visible; the BTB only samples it when wren_o is set.
  assign wren_o      = pop;
  assign wr_index_o  = idx_q[head_q];
  assign wr_tag_o    = tag_q[head_q];
  assign wr_target_o = tgt_q[head_q];
  assign count_o     = count_q;

endmodule
